ram_sync_prog: RTL and testbench



---
 rtl/ram_sync_prog.sv | 58 +++++
 tb/tb_ram_sync_prog.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sync_prog.sv
// ram_sync_prog: parametrised W-bus RAM with post-reset zero-fill and front-panel program loader
module ram_sync_prog #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_program_mode,
   input  logic [DATA_WIDTH-1:0] i_data_program,
   input  logic                  i_prog_strobe,
   input  logic                  i_prog_addr_load,
   input  logic [ADDR_WIDTH-1:0] i_address,
   input  logic                  i_write_enable,
   input  logic                  i_read_enable,
   inout  wire  [DATA_WIDTH-1:0] io_data,
   output logic                  o_busy,
   output logic [ADDR_WIDTH-1:0] o_prog_addr
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   typedef enum logic [1:0] {CLEAR, RUN, PROG} state_t;
   state_t                r_state, w_next;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_cnt, r_prog_addr, w_waddr;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic                  r_strobe_prev, w_we, w_load, w_deposit, w_rd;
   // next state, single write port selection and bus-drive decision
   always_comb begin
      w_load    = (r_state == PROG) && i_prog_addr_load;
      w_deposit = (r_state == PROG) && i_prog_strobe && !r_strobe_prev && !i_prog_addr_load;
      w_rd      = (r_state == RUN) && i_read_enable && !i_write_enable;
      w_next    = (r_state == CLEAR && !(&r_cnt)) ? CLEAR : (i_program_mode ? PROG : RUN);
      w_we      = !i_reset && ((r_state == CLEAR) || w_deposit || ((r_state == RUN) && i_write_enable));
      w_waddr   = (r_state == CLEAR) ? r_cnt : ((r_state == PROG) ? r_prog_addr : i_address);
      w_wdata   = (r_state == CLEAR) ? '0 : ((r_state == PROG) ? i_data_program : io_data);
   end
   // state, clear counter, program pointer and strobe history
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= CLEAR;
         r_cnt         <= '0;
         r_prog_addr   <= '0;
         r_strobe_prev <= 1'b0;
      end else begin
         r_state       <= w_next;
         r_strobe_prev <= i_prog_strobe;
         if (r_state == CLEAR) r_cnt <= r_cnt + 1'b1;
         if (w_load) r_prog_addr <= i_address;
         else if (w_deposit) r_prog_addr <= r_prog_addr + 1'b1;
      end
   end
   // memory array, no reset: contents are cleared by the zero-fill sequence
   always_ff @(posedge i_clk) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
   end
   assign io_data     = w_rd ? r_mem[i_address] : 'z;
   assign o_busy      = (r_state == CLEAR);
   assign o_prog_addr = r_prog_addr;
endmodule

// File: tb/tb_ram_sync_prog.sv
// tb_ram_sync_prog: scoreboard bench for ram_sync_prog at 8x16 and 16x64
module tb_ram_sync_prog;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int checks = 0;
   int errors = 0;
   logic        a_rst = 1'b1, a_pm = 1'b0, a_st = 1'b0, a_pl = 1'b0, a_we = 1'b0, a_re = 1'b0, a_den = 1'b0, a_chk = 1'b0;
   logic [7:0]  a_dp = '0, a_dv = '0;
   logic [3:0]  a_addr = '0, a_paddr, pa;
   logic        a_busy;
   wire  [7:0]  a_bus;
   assign a_bus = a_den ? a_dv : 8'bz;
   logic        b_rst = 1'b1, b_pm = 1'b0, b_st = 1'b0, b_pl = 1'b0, b_we = 1'b0, b_re = 1'b0, b_den = 1'b0, b_chk = 1'b0;
   logic [15:0] b_dp = '0, b_dv = '0;
   logic [5:0]  b_addr = '0, b_paddr;
   logic        b_busy;
   wire  [15:0] b_bus;
   assign b_bus = b_den ? b_dv : 16'bz;
   logic [7:0]  ma [16];
   logic [15:0] mb [64];
   logic [7:0]  qa [$];
   logic [15:0] qb [$];
   logic [7:0]  ea;
   logic [15:0] eb;
   int          n;

   ram_sync_prog dut_a (
      .i_clk(clk), .i_reset(a_rst), .i_program_mode(a_pm), .i_data_program(a_dp),
      .i_prog_strobe(a_st), .i_prog_addr_load(a_pl), .i_address(a_addr),
      .i_write_enable(a_we), .i_read_enable(a_re), .io_data(a_bus),
      .o_busy(a_busy), .o_prog_addr(a_paddr)
   );
   ram_sync_prog #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) dut_b (
      .i_clk(clk), .i_reset(b_rst), .i_program_mode(b_pm), .i_data_program(b_dp),
      .i_prog_strobe(b_st), .i_prog_addr_load(b_pl), .i_address(b_addr),
      .i_write_enable(b_we), .i_read_enable(b_re), .io_data(b_bus),
      .o_busy(b_busy), .o_prog_addr(b_paddr)
   );

   // read monitor: pops the expected word queued by the read stimulus
   always @(negedge clk) begin
      if (a_chk) begin
         ea = qa.pop_front();
         checks++;
         if (a_bus !== ea) begin
            errors++;
            $display("FAIL read_a addr %0d got %h exp %h", a_addr, a_bus, ea);
         end
      end
      if (b_chk) begin
         eb = qb.pop_front();
         checks++;
         if (b_bus !== eb) begin
            errors++;
            $display("FAIL read_b addr %0d got %h exp %h", b_addr, b_bus, eb);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_a(input logic [3:0] ad);
      a_addr = ad; a_we = 1'b0; a_re = 1'b1; a_den = 1'b0;
      qa.push_back(ma[ad]);
      a_chk = 1'b1;
      @(negedge clk);
      #1;
      a_chk = 1'b0; a_re = 1'b0;
   endtask

   task automatic wr_a(input logic [3:0] ad, input logic [7:0] v);
      a_addr = ad; a_we = 1'b1; a_den = 1'b1; a_dv = v;
      step();
      ma[ad] = v;
      a_we = 1'b0; a_den = 1'b0;
   endtask

   task automatic dep_a(input logic [7:0] v);
      a_dp = v; a_st = 1'b1;
      repeat (5) step();
      a_st = 1'b0;
      step();
      ma[pa] = v;
      pa = pa + 1'b1;
   endtask

   task automatic count_busy_a(output int c);
      c = 0;
      @(negedge clk);
      while (a_busy && c < 200) begin
         c++;
         @(negedge clk);
      end
   endtask

   task automatic rd_b(input logic [5:0] ad);
      b_addr = ad; b_we = 1'b0; b_re = 1'b1; b_den = 1'b0;
      qb.push_back(mb[ad]);
      b_chk = 1'b1;
      @(negedge clk);
      #1;
      b_chk = 1'b0; b_re = 1'b0;
   endtask

   task automatic test_reset();
      a_rst = 1'b1;
      step();
      checks++;
      if (a_busy !== 1'b1 || a_paddr !== 4'd0) begin
         errors++;
         $display("FAIL reset_state busy %b paddr %0d exp 1 0", a_busy, a_paddr);
      end
      a_rst = 1'b0;
      count_busy_a(n);
      checks++;
      if (n != 16) begin
         errors++;
         $display("FAIL clear_cycles got %0d exp 16", n);
      end
      for (int i = 0; i < 16; i++) ma[i] = 8'h00;
      for (int i = 0; i < 16; i++) rd_a(4'(i));
   endtask

   task automatic test_run();
      wr_a(4'd3, 8'hA5);
      wr_a(4'd15, 8'h3C);
      rd_a(4'd3);
      rd_a(4'd15);
      a_addr = 4'd3; a_we = 1'b1; a_re = 1'b1; a_den = 1'b1; a_dv = 8'h11;
      @(negedge clk);
      checks++;
      if (a_bus !== 8'h11) begin
         errors++;
         $display("FAIL we_over_re_bus got %h exp 11", a_bus);
      end
      #1;
      a_we = 1'b0; a_re = 1'b0; a_den = 1'b0;
      ma[3] = 8'h11;
      rd_a(4'd3);
   endtask

   task automatic test_prog();
      a_pm = 1'b1;
      step();
      a_pl = 1'b1; a_addr = 4'd14;
      step();
      a_pl = 1'b0;
      pa = 4'd14;
      checks++;
      if (a_paddr !== 4'd14) begin
         errors++;
         $display("FAIL prog_load got %0d exp 14", a_paddr);
      end
      a_re = 1'b1; a_addr = 4'd3; a_den = 1'b1; a_dv = 8'h00;
      @(negedge clk);
      checks++;
      if (a_bus !== 8'h00) begin
         errors++;
         $display("FAIL prog_bus_z got %h exp 00", a_bus);
      end
      #1;
      a_re = 1'b0; a_den = 1'b0;
      dep_a(8'h01);
      dep_a(8'h02);
      dep_a(8'h03);
      checks++;
      if (a_paddr !== pa || pa !== 4'd1) begin
         errors++;
         $display("FAIL prog_ptr_wrap got %0d exp 1", a_paddr);
      end
      a_pm = 1'b0;
      step();
      rd_a(4'd14);
      rd_a(4'd15);
      rd_a(4'd0);
      rd_a(4'd1);
   endtask

   task automatic test_load_collision();
      a_pm = 1'b1;
      step();
      a_pl = 1'b1; a_addr = 4'd7; a_st = 1'b1; a_dp = 8'h77;
      step();
      a_pl = 1'b0;
      step();
      a_st = 1'b0;
      step();
      pa = 4'd7;
      checks++;
      if (a_paddr !== 4'd7) begin
         errors++;
         $display("FAIL load_priority got %0d exp 7", a_paddr);
      end
      a_pm = 1'b0;
      step();
      rd_a(4'd1);
      rd_a(4'd7);
      a_pm = 1'b1;
      step();
      dep_a(8'h5A);
      checks++;
      if (a_paddr !== 4'd8) begin
         errors++;
         $display("FAIL after_load_deposit got %0d exp 8", a_paddr);
      end
      a_pm = 1'b0;
      step();
      rd_a(4'd7);
   endtask

   task automatic test_strobe_entry();
      a_st = 1'b1; a_dp = 8'hEE;
      step();
      a_pm = 1'b1;
      step();
      step();
      checks++;
      if (a_paddr !== pa) begin
         errors++;
         $display("FAIL held_strobe_entry got %0d exp %0d", a_paddr, pa);
      end
      a_st = 1'b0; a_pm = 1'b0;
      step();
      rd_a(4'd8);
   endtask

   task automatic test_reset_mid();
      a_rst = 1'b1;
      step();
      a_rst = 1'b0;
      repeat (9) step();
      a_re = 1'b1; a_addr = 4'd15;
      a_rst = 1'b1;
      step();
      a_den = 1'b1; a_dv = 8'h00;
      #1;
      checks++;
      if (a_bus !== 8'h00 || a_busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_bus_z got %h busy %b exp 00 1", a_bus, a_busy);
      end
      a_rst = 1'b0; a_re = 1'b0; a_den = 1'b0;
      count_busy_a(n);
      checks++;
      if (n != 16) begin
         errors++;
         $display("FAIL mid_clear_cycles got %0d exp 16", n);
      end
      for (int i = 0; i < 16; i++) ma[i] = 8'h00;
      for (int i = 0; i < 16; i++) rd_a(4'(i));
      wr_a(4'd9, 8'h99);
      a_pm = 1'b1;
      step();
      a_pl = 1'b1; a_addr = 4'd5;
      step();
      a_pl = 1'b0;
      pa = 4'd5;
      dep_a(8'h42);
      a_rst = 1'b1;
      step();
      a_rst = 1'b0; a_pm = 1'b0;
      checks++;
      if (a_paddr !== 4'd0) begin
         errors++;
         $display("FAIL mid_prog_reset_ptr got %0d exp 0", a_paddr);
      end
      count_busy_a(n);
      checks++;
      if (n != 16) begin
         errors++;
         $display("FAIL mid_prog_clear_cycles got %0d exp 16", n);
      end
      for (int i = 0; i < 16; i++) ma[i] = 8'h00;
      for (int i = 0; i < 16; i++) rd_a(4'(i));
   endtask

   task automatic test_wide();
      b_rst = 1'b1;
      step();
      b_rst = 1'b0;
      n = 0;
      @(negedge clk);
      while (b_busy && n < 400) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != 64) begin
         errors++;
         $display("FAIL wide_clear_cycles got %0d exp 64", n);
      end
      for (int i = 0; i < 64; i++) mb[i] = 16'h0000;
      #1;
      b_addr = 6'd63; b_we = 1'b1; b_den = 1'b1; b_dv = 16'hBEEF;
      step();
      mb[63] = 16'hBEEF;
      b_we = 1'b0; b_den = 1'b0;
      rd_b(6'd63);
      rd_b(6'd0);
      b_pm = 1'b1;
      step();
      b_pl = 1'b1; b_addr = 6'd63;
      step();
      b_pl = 1'b0; b_dp = 16'h1234; b_st = 1'b1;
      step();
      b_st = 1'b0;
      step();
      mb[63] = 16'h1234;
      checks++;
      if (b_paddr !== 6'd0) begin
         errors++;
         $display("FAIL wide_ptr_wrap got %0d exp 0", b_paddr);
      end
      b_pm = 1'b0;
      step();
      rd_b(6'd63);
      rd_b(6'd0);
   endtask

   initial begin
      test_reset();
      test_run();
      test_prog();
      test_load_collision();
      test_strobe_entry();
      test_reset_mid();
      test_wide();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
